intel_vvp_exposure_fusion_sync: RTL and testbench
=================================================

# intel_vvp_exposure_fusion_sync

Frame-alignment controller in front of the exposure fusion line buffer. It accepts the long-exposure (in_0) and short-exposure (in_1) AXI4-S VVP Lite streams and discards beats on each until both streams present a start-of-frame together. It then forwards them in lock-step as one joined double-width stream, and drops back to re-seek if the streams diverge. It runs in the video clock domain; its enable comes from the CPU register block.

## Interface
- TDATA_WIDTH, 32: per-input tdata width in bits (multiple of 8).
- TUSER_WIDTH, 4: per-input tuser width; bit 0 is SOF.
- DROP_COUNT_WIDTH, 16: width of the saturating drop counter.

- main_clock  in  1  video clock; all logic is on its rising edge.
- main_reset  in  1  asynchronous, active-high reset.
- r_vid_enable  in  1  run enable, synchronous to main_clock.
- axi4s_vid_in_0_tdata/tlast/tuser/tvalid  in  TDATA_WIDTH/1/TUSER_WIDTH/1  long-exposure stream.
- axi4s_vid_in_0_tready  out  1
- axi4s_vid_in_1_tdata/tlast/tuser/tvalid  in  TDATA_WIDTH/1/TUSER_WIDTH/1  short-exposure stream.
- axi4s_vid_in_1_tready  out  1
- axi4s_vid_out_tdata  out  2*TDATA_WIDTH  {in_1 tdata, in_0 tdata}.
- axi4s_vid_out_tlast  out  1  tlast from in_0.
- axi4s_vid_out_tuser  out  TUSER_WIDTH  tuser from in_0.
- axi4s_vid_out_tvalid  out  1
- axi4s_vid_out_tready  in  1
- sync_locked  out  1  high while in LOCKED.
- mismatch_pulse  out  1  one-cycle pulse on a detected misalignment.
- drop_count  out  DROP_COUNT_WIDTH  saturating count of discarded input beats, both streams summed.

## Operation
- States: IDLE, SEEK, LOCKED.
- IDLE:
  - Both input treadys are 1, and every beat is discarded; discards are counted.
  - Output is not loaded.
  - When r_vid_enable=1, move to SEEK on the next cycle.
- SEEK:
  - Each stream is handled independently. If its head beat is valid with tuser[0]=0, tready=1 and the beat is discarded (counted). If the head beat has tuser[0]=1, tready=0 and the beat is held.
  - When both heads are valid with SOF, move to LOCKED. Neither SOF beat is consumed in SEEK.
  - r_vid_enable=0 returns the block to IDLE.
- LOCKED:
  - A joint transfer requires in_0 valid, in_1 valid, and an output register that is empty or being emptied this cycle (out_tvalid=0 or out_tready=1).
  - Both input treadys equal that condition. Both streams are always consumed on the same cycle.
  - r_vid_enable=0 takes effect only when both heads are valid SOF beats: those beats are not consumed, and the state goes to IDLE. This stops the block on a frame boundary.
- Mismatch check (see Configuration): a joint beat mismatches when the two tlast values differ or the two tuser[0] values differ.
  - The mismatched beat pair is consumed and discarded; 2 is added to drop_count.
  - mismatch_pulse=1 for one cycle, and the state goes to SEEK.
- drop_count saturates at all-ones and clears only on reset. It adds 0, 1 or 2 per cycle.

## Timing
- Reset values: both in tready=0, out_tvalid=0, out_tdata/tlast/tuser=0, sync_locked=0, mismatch_pulse=0, drop_count=0, state=IDLE.
- Output stage is a single register. Latency from joint input handshake to out_tvalid is 1 cycle.
- Full throughput: 1 joint beat per cycle while out_tready=1.
- out_tvalid and the output payload hold stable while out_tvalid=1 and out_tready=0.
- tready may depend combinationally on tvalid and out_tready. There is no combinational path from tdata.
- sync_locked is registered and follows the state (high in the cycle after entering LOCKED).
- Reset asserted mid-frame clears all state immediately. Held output data is lost.
- An output beat held when the block leaves LOCKED (mismatch or disable) still completes normally to downstream.

## Configuration
- INTEL_VVP_EXPOSURE_FUSION_SYNC_CHECK_EN:
  - Defined: the mismatch check is compiled in, as described in Operation.
  - Undefined: there is no check. LOCKED leaves only through disable, mismatch_pulse is tied to 0, and in LOCKED the tlast/tuser of in_1 are ignored.

## Test plan
- Reset, then enable=1 with in_0 SOF at beat 0 and in_1 SOF preceded by 3 non-SOF beats -> 3 beats dropped, drop_count=3, sync_locked=1, and the first out beat is {in_1 SOF data, in_0 SOF data} with tuser[0]=1.
- LOCKED, 1920-beat lines, out_tready toggling 1/0 -> no beat lost or duplicated, the output is stable while stalled, and tlast appears every 1920 output beats.
- CHECK_EN defined, in_1 tlast one beat early -> mismatch_pulse for 1 cycle, drop_count +2, state SEEK, and relock at the next joint SOF.
- enable=0 mid-line -> traffic continues until both heads show SOF, then IDLE, with neither SOF consumed; subsequent beats are drained and counted.
- Force 70000 dropped beats (DROP_COUNT_WIDTH=16) -> drop_count holds at 65535.
- Assert main_reset while out_tvalid=1 -> all outputs return to their reset values in the same cycle.

Source files
------------

// File: rtl/intel_vvp_exposure_fusion_sync.sv
// intel_vvp_exposure_fusion_sync
// Aligns the long-exposure (in_0) and short-exposure (in_1) video streams on a
// common start-of-frame and forwards them in lock-step as one joined stream
// {in_1 tdata, in_0 tdata}. Beats discarded while seeking are counted.
// Optional feature macro: INTEL_VVP_EXPOSURE_FUSION_SYNC_CHECK_EN enables the
// per-beat tlast/SOF mismatch check while locked.
module intel_vvp_exposure_fusion_sync #(
    parameter int TDATA_WIDTH      = 32,
    parameter int TUSER_WIDTH      = 4,
    parameter int DROP_COUNT_WIDTH = 16
) (
    input  logic                        main_clock,
    input  logic                        main_reset,
    input  logic                        r_vid_enable,

    input  logic [TDATA_WIDTH-1:0]      axi4s_vid_in_0_tdata,
    input  logic                        axi4s_vid_in_0_tlast,
    input  logic [TUSER_WIDTH-1:0]      axi4s_vid_in_0_tuser,
    input  logic                        axi4s_vid_in_0_tvalid,
    output logic                        axi4s_vid_in_0_tready,

    input  logic [TDATA_WIDTH-1:0]      axi4s_vid_in_1_tdata,
    input  logic                        axi4s_vid_in_1_tlast,
    input  logic [TUSER_WIDTH-1:0]      axi4s_vid_in_1_tuser,
    input  logic                        axi4s_vid_in_1_tvalid,
    output logic                        axi4s_vid_in_1_tready,

    output logic [2*TDATA_WIDTH-1:0]    axi4s_vid_out_tdata,
    output logic                        axi4s_vid_out_tlast,
    output logic [TUSER_WIDTH-1:0]      axi4s_vid_out_tuser,
    output logic                        axi4s_vid_out_tvalid,
    input  logic                        axi4s_vid_out_tready,

    output logic                        sync_locked,
    output logic                        mismatch_pulse,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEEK   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic sof_0;
    logic sof_1;
    logic out_free;
    logic joint;
    logic stop;
    logic ready_0;
    logic ready_1;
    logic mismatch;
    logic load;
    logic [1:0] drop_inc;
    logic [DROP_COUNT_WIDTH:0] drop_sum;

    // Heads presenting a valid start-of-frame beat.
    assign sof_0    = axi4s_vid_in_0_tvalid & axi4s_vid_in_0_tuser[0];
    assign sof_1    = axi4s_vid_in_1_tvalid & axi4s_vid_in_1_tuser[0];
    // Output register can take a new beat when empty or draining this cycle.
    assign out_free = ~axi4s_vid_out_tvalid | axi4s_vid_out_tready;
    assign joint    = axi4s_vid_in_0_tvalid & axi4s_vid_in_1_tvalid & out_free;
    // Disable only lands on a frame boundary, with both SOF heads waiting.
    assign stop     = ~r_vid_enable & sof_0 & sof_1;

    // Readies are held low during reset so nothing is accepted then.
    assign axi4s_vid_in_0_tready = ready_0 & ~main_reset;
    assign axi4s_vid_in_1_tready = ready_1 & ~main_reset;

`ifdef INTEL_VVP_EXPOSURE_FUSION_SYNC_CHECK_EN
    logic unused_inputs;
    assign unused_inputs = ^{axi4s_vid_in_1_tuser[TUSER_WIDTH-1:1]};
`else
    logic unused_inputs;
    assign unused_inputs = ^{axi4s_vid_in_1_tuser, axi4s_vid_in_1_tlast};
`endif

    // Next-state, handshake and discard-count decode.
    always_comb begin
        state_next = state;
        ready_0    = 1'b0;
        ready_1    = 1'b0;
        mismatch   = 1'b0;
        load       = 1'b0;
        drop_inc   = 2'd0;
        case (state)
            ST_IDLE: begin
                ready_0  = 1'b1;
                ready_1  = 1'b1;
                drop_inc = {1'b0, axi4s_vid_in_0_tvalid} + {1'b0, axi4s_vid_in_1_tvalid};
                if (r_vid_enable) begin
                    state_next = ST_SEEK;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SEEK: begin
                // Non-SOF heads are discarded; SOF heads wait for the partner.
                ready_0  = axi4s_vid_in_0_tvalid & ~axi4s_vid_in_0_tuser[0];
                ready_1  = axi4s_vid_in_1_tvalid & ~axi4s_vid_in_1_tuser[0];
                drop_inc = {1'b0, ready_0} + {1'b0, ready_1};
                if (!r_vid_enable) begin
                    state_next = ST_IDLE;
                end else if (sof_0 && sof_1) begin
                    state_next = ST_LOCKED;
                end else begin
                    state_next = ST_SEEK;
                end
            end
            ST_LOCKED: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (joint) begin
                    ready_0 = 1'b1;
                    ready_1 = 1'b1;
`ifdef INTEL_VVP_EXPOSURE_FUSION_SYNC_CHECK_EN
                    if ((axi4s_vid_in_0_tlast != axi4s_vid_in_1_tlast) ||
                        (axi4s_vid_in_0_tuser[0] != axi4s_vid_in_1_tuser[0])) begin
                        mismatch   = 1'b1;
                        drop_inc   = 2'd2;
                        state_next = ST_SEEK;
                    end else begin
                        load = 1'b1;
                    end
`else
                    load = 1'b1;
`endif
                end else begin
                    state_next = ST_LOCKED;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Saturating sum of the discard counter.
    assign drop_sum = {1'b0, drop_count} + {{(DROP_COUNT_WIDTH-1){1'b0}}, drop_inc};

    // State register, status flags, drop counter and the output stage.
    always_ff @(posedge main_clock or posedge main_reset) begin
        if (main_reset) begin
            state                <= ST_IDLE;
            sync_locked          <= 1'b0;
            mismatch_pulse       <= 1'b0;
            drop_count           <= {DROP_COUNT_WIDTH{1'b0}};
            axi4s_vid_out_tvalid <= 1'b0;
            axi4s_vid_out_tdata  <= {(2*TDATA_WIDTH){1'b0}};
            axi4s_vid_out_tlast  <= 1'b0;
            axi4s_vid_out_tuser  <= {TUSER_WIDTH{1'b0}};
        end else begin
            state          <= state_next;
            sync_locked    <= (state == ST_LOCKED);
            mismatch_pulse <= mismatch;
            if (drop_sum[DROP_COUNT_WIDTH]) begin
                drop_count <= {DROP_COUNT_WIDTH{1'b1}};
            end else begin
                drop_count <= drop_sum[DROP_COUNT_WIDTH-1:0];
            end
            // A held beat drains normally even after leaving LOCKED.
            if (load) begin
                axi4s_vid_out_tvalid <= 1'b1;
                axi4s_vid_out_tdata  <= {axi4s_vid_in_1_tdata, axi4s_vid_in_0_tdata};
                axi4s_vid_out_tlast  <= axi4s_vid_in_0_tlast;
                axi4s_vid_out_tuser  <= axi4s_vid_in_0_tuser;
            end else if (axi4s_vid_out_tready) begin
                axi4s_vid_out_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_intel_vvp_exposure_fusion_sync.sv
// Directed self-checking bench for intel_vvp_exposure_fusion_sync.
module tb_intel_vvp_exposure_fusion_sync;

    localparam int DW   = 32;
    localparam int UW   = 4;
    localparam int CW   = 16;
    localparam int LINE = 1920;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic [DW-1:0] d0, d1;
    logic l0, l1, v0, v1, r0, r1;
    logic [UW-1:0] u0, u1;
    logic [2*DW-1:0] out_data;
    logic out_last, out_valid, out_ready;
    logic [UW-1:0] out_user;
    logic locked, pulse;
    logic [CW-1:0] drops;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intel_vvp_exposure_fusion_sync #(
        .TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .DROP_COUNT_WIDTH(CW)
    ) dut (
        .main_clock(clk), .main_reset(rst), .r_vid_enable(enable),
        .axi4s_vid_in_0_tdata(d0), .axi4s_vid_in_0_tlast(l0), .axi4s_vid_in_0_tuser(u0),
        .axi4s_vid_in_0_tvalid(v0), .axi4s_vid_in_0_tready(r0),
        .axi4s_vid_in_1_tdata(d1), .axi4s_vid_in_1_tlast(l1), .axi4s_vid_in_1_tuser(u1),
        .axi4s_vid_in_1_tvalid(v1), .axi4s_vid_in_1_tready(r1),
        .axi4s_vid_out_tdata(out_data), .axi4s_vid_out_tlast(out_last),
        .axi4s_vid_out_tuser(out_user), .axi4s_vid_out_tvalid(out_valid),
        .axi4s_vid_out_tready(out_ready),
        .sync_locked(locked), .mismatch_pulse(pulse), .drop_count(drops)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv0, input logic [DW-1:0] id0, input logic il0, input logic is0,
                         input logic iv1, input logic [DW-1:0] id1, input logic il1, input logic is1);
        v0 = iv0; d0 = id0; l0 = il0; u0 = {3'b000, is0};
        v1 = iv1; d1 = id1; l1 = il1; u1 = {3'b000, is1};
    endtask

    initial begin
        int exp_drop;
        int k, e, cyc, lasts;
        logic hs, have_held;
        logic [2*DW-1:0] held;

        rst = 1'b1; enable = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        step(); step();
        // Reset state.
        chk("rst_tready0", r0, 1'b0);
        chk("rst_tready1", r1, 1'b0);
        chk("rst_tvalid", out_valid, 1'b0);
        chk("rst_tdata", out_data, 64'h0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_pulse", pulse, 1'b0);
        chk("rst_drops", drops, 16'h0);
        rst = 1'b0;
        step();
        chk("idle_tready0", r0, 1'b1);

        // Seek: in_0 SOF at once, in_1 preceded by three non-SOF beats.
        enable = 1'b1;
        step();
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b1, 32'hDEAD_0001, 1'b0, 1'b0);
        #1;
        chk("seek_hold_sof0", r0, 1'b0);
        chk("seek_drop_1", r1, 1'b1);
        step();
        d1 = 32'hDEAD_0002; step();
        d1 = 32'hDEAD_0003; step();
        exp_drop = 3;
        chk("seek_drops3", drops, exp_drop[CW-1:0]);
        drive(1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b1, 32'hB000_0000, 1'b0, 1'b1);
        #1;
        chk("seek_both_sof_r0", r0, 1'b0);
        chk("seek_both_sof_r1", r1, 1'b0);
        step();
        chk("lock_joint_ready", {r0, r1}, 2'b11);
        step();
        chk("first_valid", out_valid, 1'b1);
        chk("first_data", out_data, {32'hB000_0000, 32'hA000_0000});
        chk("first_sof", out_user, 4'h1);
        chk("first_locked", locked, 1'b1);
        chk("first_drops", drops, exp_drop[CW-1:0]);

        // Two 1920-beat lines with out_tready toggling.
        k = 1; e = 0; cyc = 0; lasts = 0; have_held = 1'b0; held = '0;
        while (e < 2*LINE && cyc < 20000) begin
            out_ready = cyc[0];
            if (k < 2*LINE)
                drive(1'b1, 32'hA000_0000 + k, (k % LINE) == LINE-1, 1'b0,
                      1'b1, 32'hB000_0000 + k, (k % LINE) == LINE-1, 1'b0);
            else
                drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            if (have_held) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, held);
            end
            have_held = 1'b0;
            if (out_valid && out_ready) begin
                chk("line_data", out_data, {32'hB000_0000 + e, 32'hA000_0000 + e});
                chk("line_last", out_last, (e % LINE) == LINE-1);
                chk("line_user", out_user, (e == 0) ? 4'h1 : 4'h0);
                if (out_last) lasts++;
                e++;
            end else if (out_valid) begin
                held = out_data;
                have_held = 1'b1;
            end
            chk("lockstep_ready", r0, r1);
            hs = r0 & v0;
            step();
            if (hs) k++;
            cyc++;
        end
        chk("line_beats", e, 2*LINE);
        chk("line_lasts", lasts, 2);
        chk("line_drops", drops, exp_drop[CW-1:0]);

        // New frame, then a pair whose tlast values disagree.
        out_ready = 1'b1;
        drive(1'b1, 32'hC000_0000, 1'b0, 1'b1, 1'b1, 32'hD000_0000, 1'b0, 1'b1);
        #1;
        chk("f2_ready", {r0, r1}, 2'b11);
        step();
        chk("f2_sof_data", out_data, {32'hD000_0000, 32'hC000_0000});
        drive(1'b1, 32'hC000_0001, 1'b0, 1'b0, 1'b1, 32'hD000_0001, 1'b1, 1'b0);
        #1;
        chk("mm_ready", {r0, r1}, 2'b11);
        step();
`ifdef INTEL_VVP_EXPOSURE_FUSION_SYNC_CHECK_EN
        exp_drop = exp_drop + 2;
        chk("mm_pulse", pulse, 1'b1);
        chk("mm_no_out", out_valid, 1'b0);
        chk("mm_drops", drops, exp_drop[CW-1:0]);
        drive(1'b1, 32'hC000_0002, 1'b0, 1'b0, 1'b1, 32'hD000_0100, 1'b0, 1'b1);
        #1;
        chk("mm_seek_r0", r0, 1'b1);
        chk("mm_seek_r1", r1, 1'b0);
        step();
        exp_drop = exp_drop + 1;
        chk("mm_pulse_end", pulse, 1'b0);
        chk("mm_unlocked", locked, 1'b0);
        chk("mm_seek_drops", drops, exp_drop[CW-1:0]);
        drive(1'b1, 32'hC000_0100, 1'b0, 1'b1, 1'b1, 32'hD000_0100, 1'b0, 1'b1);
        #1;
        chk("relock_hold", {r0, r1}, 2'b00);
        step();
        step();
        chk("relock_data", out_data, {32'hD000_0100, 32'hC000_0100});
        chk("relock_sof", out_user, 4'h1);
        chk("relock_locked", locked, 1'b1);
`else
        chk("nochk_pulse", pulse, 1'b0);
        chk("nochk_valid", out_valid, 1'b1);
        chk("nochk_data", out_data, {32'hD000_0001, 32'hC000_0001});
        chk("nochk_last", out_last, 1'b0);
        chk("nochk_drops", drops, exp_drop[CW-1:0]);
`endif

        // Disable mid-line: traffic continues until both heads are SOF.
        enable = 1'b0;
        drive(1'b1, 32'hE000_0001, 1'b0, 1'b0, 1'b1, 32'hF000_0001, 1'b0, 1'b0);
        #1;
        chk("dis_flow", {r0, r1}, 2'b11);
        step();
        chk("dis_data", out_data, {32'hF000_0001, 32'hE000_0001});
        drive(1'b1, 32'hE000_0100, 1'b0, 1'b1, 1'b1, 32'hF000_0100, 1'b0, 1'b1);
        #1;
        chk("dis_sof_hold", {r0, r1}, 2'b00);
        step();
        chk("dis_drained", out_valid, 1'b0);
        chk("idle_drain_ready", {r0, r1}, 2'b11);
        step();
        exp_drop = exp_drop + 2;
        chk("idle_drain_drops", drops, exp_drop[CW-1:0]);
        chk("idle_unlocked", locked, 1'b0);

        // Saturation: 2 drops per cycle in IDLE, 70000 in total.
        drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 32'h2, 1'b0, 1'b0);
        repeat (32000) step();
        exp_drop = exp_drop + 64000;
        chk("sat_pre", drops, exp_drop[CW-1:0]);
        repeat (3000) step();
        chk("sat_hold", drops, 16'hFFFF);

        // Reset while an output beat is held.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        enable = 1'b1;
        step();
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h9ABC_DEF0, 1'b0, 1'b1);
        step();
        step();
        chk("pre_rst_valid", out_valid, 1'b1);
        chk("pre_rst_drops", drops, 16'hFFFF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_data", out_data, 64'h0);
        chk("arst_user", out_user, 4'h0);
        chk("arst_ready", {r0, r1}, 2'b00);
        chk("arst_locked", locked, 1'b0);
        chk("arst_drops", drops, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
